// File: rtl/grey_to_color_if.sv
// grey_to_color_if: pixel stream in, RGB stream out, plus frame status
interface grey_to_color_if;
  logic        mode;
  logic [7:0]  in_grey;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_red;
  logic [7:0]  out_green;
  logic [7:0]  out_blue;
  logic        out_valid;
  logic        out_ready;
  logic        out_sof;
  logic        out_eol;
  logic        out_eof;
  logic [15:0] frame_count;
  modport master (
    output mode, in_grey, in_valid, out_ready,
    input  in_ready, out_red, out_green, out_blue, out_valid, out_sof, out_eol, out_eof, frame_count
  );
  modport slave (
    input  mode, in_grey, in_valid, out_ready,
    output in_ready, out_red, out_green, out_blue, out_valid, out_sof, out_eol, out_eof, frame_count
  );
endinterface

// File: rtl/grey_to_color.sv
// grey_to_color: 2-stage pipeline mapping grey pixels to replicated grey or a 4-segment pseudocolor ramp
module grey_to_color #(
  parameter int WIDTH  = 128,
  parameter int HEIGHT = 128
) (
  input logic clk,
  input logic rst,
  grey_to_color_if.slave px
);
  localparam int XW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  localparam int YW = HEIGHT > 1 ? $clog2(HEIGHT) : 1;
  typedef struct packed {
    logic [7:0] grey;
    logic [1:0] seg;
    logic [5:0] off;
    logic       mode;
    logic       sof;
    logic       eol;
    logic       eof;
  } s1_t;
  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       sof;
    logic       eol;
    logic       eof;
  } s2_t;
  s1_t s1_q, s1_d;
  s2_t s2_q, s2_d;
  logic s1_valid_q, s2_valid_q;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic mode_q, mode_now;
  logic [15:0] fc_q;
  logic s1_load, s2_load, in_ready, accept, x_last, y_last, sof;
  logic [7:0] o4;
  always_comb begin
    s2_load  = !s2_valid_q || px.out_ready;
    s1_load  = !s1_valid_q || s2_load;
    in_ready = !rst && s1_load;
    accept   = px.in_valid && in_ready;
    x_last   = x_q == XW'(WIDTH - 1);
    y_last   = y_q == YW'(HEIGHT - 1);
    sof      = x_q == '0 && y_q == '0;
    // mode is only taken from the port on a frame's first pixel
    mode_now = sof ? px.mode : mode_q;
    x_d      = x_last ? '0 : x_q + 1'b1;
    y_d      = x_last ? (y_last ? '0 : y_q + 1'b1) : y_q;
    s1_d.grey = px.in_grey;
    s1_d.seg  = px.in_grey[7:6];
    s1_d.off  = px.in_grey[5:0];
    s1_d.mode = mode_now;
    s1_d.sof  = sof;
    s1_d.eol  = x_last;
    s1_d.eof  = x_last && y_last;
    o4 = {s1_q.off, 2'b00};
    s2_d.r = !s1_q.mode ? s1_q.grey : s1_q.seg[1] ? (s1_q.seg[0] ? 8'hFF : o4) : 8'h00;
    s2_d.g = !s1_q.mode ? s1_q.grey : s1_q.seg == 2'd0 ? o4 : s1_q.seg == 2'd3 ? ~o4 : 8'hFF;
    s2_d.b = !s1_q.mode ? s1_q.grey : s1_q.seg[1] ? 8'h00 : (s1_q.seg[0] ? ~o4 : 8'hFF);
    s2_d.sof = s1_q.sof;
    s2_d.eol = s1_q.eol;
    s2_d.eof = s1_q.eof;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_q       <= '0;
      s2_q       <= '0;
      x_q        <= '0;
      y_q        <= '0;
      mode_q     <= 1'b0;
      fc_q       <= '0;
    end else begin
      if (s1_load) s1_valid_q <= accept;
      if (s1_load && accept) s1_q <= s1_d;
      if (s2_load) s2_valid_q <= s1_valid_q;
      if (s2_load && s1_valid_q) s2_q <= s2_d;
      if (accept) begin
        x_q <= x_d;
        y_q <= y_d;
      end
      if (accept && sof) mode_q <= px.mode;
      if (s2_valid_q && px.out_ready && s2_q.eof) fc_q <= fc_q + 16'd1;
    end
  end
  assign px.in_ready    = in_ready;
  assign px.out_valid   = s2_valid_q;
  assign px.out_red     = s2_q.r;
  assign px.out_green   = s2_q.g;
  assign px.out_blue    = s2_q.b;
  assign px.out_sof     = s2_q.sof;
  assign px.out_eol     = s2_q.eol;
  assign px.out_eof     = s2_q.eof;
  assign px.frame_count = fc_q;
endmodule

// File: tb/tb_grey_to_color.sv
// tb_grey_to_color: scoreboard bench for grey_to_color
module tb_grey_to_color;
  localparam int W = 128;
  localparam int H = 128;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rand_rdy = 1'b0;
  logic rdy_cmd = 1'b1;
  logic rnd_bit = 1'b1;
  always #5 clk = ~clk;
  grey_to_color_if bus();
  grey_to_color #(.WIDTH(W), .HEIGHT(H)) dut (.clk(clk), .rst(rst), .px(bus.slave));
  assign bus.out_ready = rand_rdy ? rnd_bit : rdy_cmd;
  always @(posedge clk) begin
    #1;
    rnd_bit = $urandom_range(0, 3) != 0;
  end
  typedef struct packed {
    logic [23:0] rgb;
    logic        sof;
    logic        eol;
    logic        eof;
    int unsigned cyc;
  } exp_t;
  exp_t sb[$];
  logic [23:0] got_q[$];
  int n_chk = 0;
  int n_fail = 0;
  int unsigned cyc = 0;
  int mx = 0;
  int my = 0;
  logic mmode = 1'b0;
  logic [15:0] efc = '0;
  logic chk_lat = 1'b0;
  logic held = 1'b0;
  logic [27:0] hold_v;
  int n_out = 0;
  int n_eol = 0;
  int n_sof = 0;
  int eof_at = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [23:0] exp_rgb(input logic m, input logic [7:0] g);
    int k;
    k = 4 * (g % 64);
    if (!m) return {g, g, g};
    case (g / 64)
      0:       return {8'd0, 8'(k), 8'd255};
      1:       return {8'd0, 8'd255, 8'(255 - k)};
      2:       return {8'(k), 8'd255, 8'd0};
      default: return {8'd255, 8'(255 - k), 8'd0};
    endcase
  endfunction
  function automatic logic [27:0] out_vec();
    return {bus.out_red, bus.out_green, bus.out_blue, bus.out_sof, bus.out_eol, bus.out_eof, bus.out_valid};
  endfunction
  always @(negedge clk) begin
    exp_t e;
    logic s;
    if (rst) begin
      sb.delete();
      mx = 0;
      my = 0;
      mmode = 1'b0;
      efc = '0;
      held = 1'b0;
    end else begin
      if (held) check("hold", out_vec(), hold_v);
      if (bus.in_valid && bus.in_ready) begin
        s = mx == 0 && my == 0;
        if (s) mmode = bus.mode;
        e.rgb = exp_rgb(mmode, bus.in_grey);
        e.sof = s;
        e.eol = mx == W - 1;
        e.eof = mx == W - 1 && my == H - 1;
        e.cyc = cyc;
        sb.push_back(e);
        if (mx == W - 1) begin
          mx = 0;
          my = my == H - 1 ? 0 : my + 1;
        end else mx++;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) check("spurious_out", 1, 0);
        else begin
          e = sb.pop_front();
          check("pixel", {bus.out_red, bus.out_green, bus.out_blue, bus.out_sof, bus.out_eol, bus.out_eof},
                {e.rgb, e.sof, e.eol, e.eof});
          if (chk_lat) check("latency", cyc - e.cyc, 2);
          got_q.push_back({bus.out_red, bus.out_green, bus.out_blue});
          n_out++;
          if (bus.out_eol) n_eol++;
          if (bus.out_sof) n_sof++;
          if (bus.out_eof) begin
            eof_at = n_out;
            efc++;
          end
        end
      end
      held = bus.out_valid && !bus.out_ready;
      hold_v = out_vec();
    end
  end
  task automatic send(input logic [7:0] g);
    int t;
    t = 0;
    bus.in_grey = g;
    bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && t < 1000) begin
      t++;
      @(negedge clk);
    end
    if (t >= 1000) check("in_ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask
  task automatic drain();
    for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    check("drain", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask
  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int b_out, b_eol, b_sof, b_got, t;
    logic [23:0] t1[5];
    t1 = '{24'h0000FF, 24'h00FFFF, 24'h00FF00, 24'hFFFF00, 24'hFF0300};
    bus.mode = 1'b0;
    bus.in_grey = '0;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("in_ready_in_rst", bus.in_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    check("reset_outputs", out_vec(), 0);
    check("reset_fc", bus.frame_count, 0);
    @(posedge clk);
    #1;
    bus.mode = 1'b1;
    b_got = got_q.size();
    chk_lat = 1'b1;
    foreach (t1[i]) send(8'(i == 4 ? 8'hFF : i * 64));
    drain();
    chk_lat = 1'b0;
    check("t1_count", got_q.size() - b_got, 5);
    foreach (t1[i]) check("t1_rgb", got_q[b_got + i], t1[i]);
    do_reset();
    bus.mode = 1'b0;
    b_got = got_q.size();
    send(8'h5A);
    bus.mode = 1'b1;
    send(8'h80);
    send(8'hC0);
    drain();
    check("t2_grey", got_q[b_got], 24'h5A5A5A);
    check("t2_keep_mode", got_q[b_got + 1], 24'h808080);
    check("t2_keep_mode2", got_q[b_got + 2], 24'hC0C0C0);
    do_reset();
    b_out = n_out;
    fork
      for (int i = 0; i < 20; i++) send(8'(i * 13));
      begin
        t = 0;
        while (!bus.out_valid && t < 50) begin
          @(negedge clk);
          t++;
        end
        @(posedge clk);
        #1;
        rdy_cmd = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("stall_in_ready", bus.in_ready, 0);
        check("stall_out_valid", bus.out_valid, 1);
        @(posedge clk);
        #1;
        rdy_cmd = 1'b1;
      end
    join
    drain();
    check("t3_count", n_out - b_out, 20);
    check("t3_fc", bus.frame_count, efc);
    do_reset();
    b_out = n_out;
    b_eol = n_eol;
    b_sof = n_sof;
    rand_rdy = 1'b1;
    for (int i = 0; i < W * H; i++) begin
      repeat ($urandom_range(0, 1)) begin
        @(posedge clk);
        #1;
      end
      bus.mode = 1'($urandom_range(0, 1));
      send(8'($urandom_range(0, 255)));
    end
    drain();
    rand_rdy = 1'b0;
    check("t4_count", n_out - b_out, W * H);
    check("t4_eol", n_eol - b_eol, H);
    check("t4_sof", n_sof - b_sof, 1);
    check("t4_eof_pos", eof_at - b_out, W * H);
    check("t4_fc", bus.frame_count, 1);
    do_reset();
    bus.mode = 1'b0;
    for (int i = 0; i < 100; i++) send(8'(i));
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("t5_out_valid", bus.out_valid, 0);
    check("t5_fc", bus.frame_count, 0);
    @(posedge clk);
    #1;
    b_sof = n_sof;
    b_got = got_q.size();
    bus.mode = 1'b1;
    send(8'hC0);
    drain();
    check("t5_sof", n_sof - b_sof, 1);
    check("t5_rgb", got_q[b_got], 24'hFFFF00);
    check("t5_fc_end", bus.frame_count, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
